// File: rtl/vdp_line_buffer.sv
// Double-buffered scanline buffer: the renderer fills the back bank while the front bank is shown.
// Video outputs leave two cycles after the timing inputs, with pixels from short fills blanked.
module vdp_line_buffer #(
  parameter int H_ACTIVE_WIDTH = 848,
  parameter int PIXEL_WIDTH    = 12
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   line_ended,
  input  logic                   active_display,
  input  logic                   hsync_in,
  input  logic                   vsync_in,
  input  logic                   wr_valid,
  input  logic [PIXEL_WIDTH-1:0] wr_data,
  output logic                   wr_ready,
  output logic                   fill_request,
  output logic [PIXEL_WIDTH-1:0] rgb_out,
  output logic                   de_out,
  output logic                   hsync_out,
  output logic                   vsync_out,
  output logic                   underrun,
  output logic [7:0]             underrun_count
);

  localparam int LEN_W  = $clog2(H_ACTIVE_WIDTH + 1);
  localparam int ADDR_W = (H_ACTIVE_WIDTH > 1) ? $clog2(H_ACTIVE_WIDTH) : 1;
  localparam logic [LEN_W-1:0] LAST_ADDR = LEN_W'(H_ACTIVE_WIDTH - 1);
  localparam logic [LEN_W-1:0] FULL_LEN  = LEN_W'(H_ACTIVE_WIDTH);

  logic [PIXEL_WIDTH-1:0]  mem_r [2][H_ACTIVE_WIDTH];
  logic                    front_r;
  logic                    fill_active_r;
  logic [1:0][LEN_W-1:0]   len_r;
  logic [LEN_W-1:0]        wr_addr_r;
  logic [LEN_W-1:0]        rd_addr_r;
  logic [PIXEL_WIDTH-1:0]  rd_data_r;
  logic                    vis_r;
  logic                    de_d_r;
  logic                    hs_d_r;
  logic                    vs_d_r;
  logic                    back_s;
  logic                    wr_fire_s;

  assign back_s    = ~front_r;
  assign wr_ready  = fill_active_r && !line_ended;
  assign wr_fire_s = wr_valid && wr_ready;

  // Fill pointer, bank swap on line_ended, and the swap-time status pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      front_r        <= 1'b0;
      fill_active_r  <= 1'b1;
      len_r          <= '0;
      wr_addr_r      <= '0;
      fill_request   <= 1'b0;
      underrun       <= 1'b0;
      underrun_count <= 8'd0;
    end else begin
      fill_request <= 1'b0;
      underrun     <= 1'b0;
      if (line_ended) begin
        // wr_ready is low on the swap cycle, so no beat can add to the captured length.
        len_r[back_s] <= wr_addr_r;
        front_r       <= back_s;
        wr_addr_r     <= '0;
        fill_active_r <= 1'b1;
        fill_request  <= 1'b1;
        if (wr_addr_r != FULL_LEN) begin
          underrun <= 1'b1;
          if (underrun_count != 8'd255) begin
            underrun_count <= underrun_count + 8'd1;
          end else begin
            underrun_count <= underrun_count;
          end
        end else begin
          underrun <= 1'b0;
        end
      end else if (wr_fire_s) begin
        wr_addr_r <= wr_addr_r + LEN_W'(1);
        if (wr_addr_r == LAST_ADDR) begin
          fill_active_r <= 1'b0;
        end else begin
          fill_active_r <= fill_active_r;
        end
      end else begin
        wr_addr_r <= wr_addr_r;
      end
    end
  end

  // Bank storage: contents survive reset, only the lengths are discarded.
  always_ff @(posedge clk) begin
    if (wr_fire_s) begin
      mem_r[back_s][wr_addr_r[ADDR_W-1:0]] <= wr_data;
    end
    if (active_display) begin
      rd_data_r <= mem_r[front_r][rd_addr_r[ADDR_W-1:0]];
    end
  end

  // Read pointer plus first pipeline stage; the visibility decision is frozen alongside the read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_addr_r <= '0;
      vis_r     <= 1'b0;
      de_d_r    <= 1'b0;
      hs_d_r    <= 1'b1;
      vs_d_r    <= 1'b1;
    end else begin
      if (line_ended) begin
        rd_addr_r <= '0;
      end else if (active_display && (rd_addr_r != FULL_LEN)) begin
        rd_addr_r <= rd_addr_r + LEN_W'(1);
      end else begin
        rd_addr_r <= rd_addr_r;
      end
      vis_r  <= active_display && (rd_addr_r < len_r[front_r]);
      de_d_r <= active_display;
      hs_d_r <= hsync_in;
      vs_d_r <= vsync_in;
    end
  end

  // Output register stage: everything leaves on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rgb_out   <= '0;
      de_out    <= 1'b0;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
    end else begin
      rgb_out   <= vis_r ? rd_data_r : '0;
      de_out    <= de_d_r;
      hsync_out <= hs_d_r;
      vsync_out <= vs_d_r;
    end
  end

endmodule

// File: doc/vdp_line_buffer.md
# vdp_line_buffer

Double-buffered scanline buffer between the pixel renderer and the VGA output pins. The renderer fills the back bank for the next line through a valid/ready stream. The timing generator's registered strobes select and read the front bank. Pixel data is re-aligned with delayed hsync/vsync/de so all video outputs leave on the same cycle. Incomplete lines are detected, blanked and counted.

## Interface
- `H_ACTIVE_WIDTH`, 848: active pixels per line; also the bank depth.
- `PIXEL_WIDTH`, 12: bits per pixel.
- `clk` in 1: pixel clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `line_ended` in 1: registered timing strobe, high for one cycle when raster_x == 0.
- `active_display` in 1: registered timing flag, high on active pixels.
- `hsync_in` in 1: timing hsync, active-low.
- `vsync_in` in 1: timing vsync, active-low.
- `wr_valid` in 1: renderer pixel valid.
- `wr_data` in PIXEL_WIDTH: renderer pixel.
- `wr_ready` out 1: buffer accepts a pixel this cycle.
- `fill_request` out 1: one-cycle pulse; the back bank is empty and filling starts at pixel 0.
- `rgb_out` out PIXEL_WIDTH: output pixel.
- `de_out` out 1: output data enable.
- `hsync_out` out 1: delayed hsync.
- `vsync_out` out 1: delayed vsync.
- `underrun` out 1: one-cycle pulse; a swap happened with the back bank incomplete.
- `underrun_count` out 8: saturating underrun counter.

## Operation
- Storage: two banks of H_ACTIVE_WIDTH x PIXEL_WIDTH, synchronous read.
  - `front` bit selects the display bank; the back bank is `!front`.
  - `len[1:0]` holds the filled length of each bank, width clog2(H_ACTIVE_WIDTH+1).
- Fill side:
  - `wr_ready = fill_active && !line_ended`. This is combinational on `line_ended` only; `wr_ready` never depends on `wr_valid`.
  - A beat is accepted when `wr_valid && wr_ready`: the bank `!front` is written at `wr_addr`, then `wr_addr` increments.
  - `fill_active` clears when the beat at `wr_addr == H_ACTIVE_WIDTH-1` is accepted. No further beats are accepted until the next swap.
- Swap, on the cycle `line_ended` == 1:
  - `len[!front] <= wr_addr`, plus 1 if a beat would land that cycle (it cannot, since `wr_ready` is 0).
  - `front <= !front`, `wr_addr <= 0`, `fill_active <= 1`.
  - `fill_request` pulses the next cycle.
  - If `wr_addr != H_ACTIVE_WIDTH`, `underrun` pulses the next cycle and `underrun_count` increments, saturating at 255.
- Swaps occur on every line, including vertical blanking. The renderer must fill every line.
- Display side:
  - `rd_addr` clears on `line_ended` and increments on every cycle with `active_display` == 1.
  - The front bank is read at `rd_addr` while `active_display` == 1.
  - If `rd_addr >= len[front]`, the pixel is forced to 0, so stale data is never shown.
  - While `active_display` == 0, `rgb_out` is 0.
- Reset values:
  - `front` = 0, `len` = {0,0}, `wr_addr` = 0, `fill_active` = 1. Bank 1 fills first; bank 0 displays black.
  - `rgb_out` = 0, `de_out` = 0, `hsync_out` = 1, `vsync_out` = 1.
  - `fill_request` = 0, `underrun` = 0, `underrun_count` = 0.
- Reset asserted mid-line discards partial fills and the bank contents' validity (`len` cleared). Memory contents are not cleared.

## Timing
- Video latency is 2 cycles: `active_display`, `hsync_in` and `vsync_in` at cycle N appear on `de_out`, `hsync_out` and `vsync_out` at N+2.
  - The pixel read at N also appears on `rgb_out` at N+2: memory read, then output register.
- The `len` compare and the bank select for the blank mux are captured at N, alongside the read. A swap at N+1 therefore does not corrupt the pixel in flight.
- Fill throughput is 1 pixel/cycle. Minimum fill time is H_ACTIVE_WIDTH cycles within the line period.
- `fill_request` and `underrun` are high at swap+1 for exactly one cycle.
- `wr_ready` is low on the `line_ended` cycle and is high again from swap+1.

## Test plan
Run with H_ACTIVE_WIDTH = 8 and PIXEL_WIDTH = 12, using a timing model with an 8-active/4-blank line.
- Reset then idle: after `reset_n` deasserts, `hsync_out`/`vsync_out` = 1 and `de_out` = 0. The first active line outputs 8 pixels of 0x000, `de_out` = 1, 2 cycles after `active_display`.
- Full fill: write 0x101..0x108 during line k. During line k+1, `rgb_out` = 0x101..0x108 in order, aligned with `de_out`, and `underrun` stays 0.
- Short fill: write only 5 pixels 0xA01..0xA05. At the swap, `underrun` pulses and `underrun_count` = 1. The next line shows 0xA01..0xA05 followed by 0x000 x3.
- Backpressure: hold `wr_valid` = 1 with 10 pixels offered. Only 8 are accepted, `wr_ready` falls after the 8th, and `fill_request` pulses once at swap+1.
- Swap collision: assert `wr_valid` on the `line_ended` cycle. `wr_ready` = 0, no write happens, and the pixel is accepted at swap+1 into the new back bank at address 0.
- Saturation and async reset: force 300 underruns and `underrun_count` holds at 255. Pulse `reset_n` low mid-line; all outputs return to their reset values immediately, without a clock edge.
